// File: rtl/blake2b_msg_buffer_pkg.sv
// Shared sizing and helpers for the BLAKE2b message-block buffer.
//   WORD_W    : message word width
//   NUM_RD    : number of combinational message read ports
//   MSG_WORDS : words per message block
//   CNT_W     : width of the in-block word counter / write index
//   IDX_W     : width of a G-unit message index
package blake2b_msg_buffer_pkg;

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned NUM_RD    = 8;
    localparam int unsigned MSG_WORDS = 16;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = 4;

    typedef logic [CNT_W-1:0] msg_cnt_t;

    // True when the counter addresses the last word of a block.
    function automatic logic is_last_word(input msg_cnt_t cnt);
        return cnt == CNT_W'(MSG_WORDS - 1);
    endfunction

endpackage

// File: rtl/blake2b_msg_buffer_bank.sv
// One 16-word message bank with a single write port and NUM_RD
// combinational read ports.
//   clk, rst   : clock, synchronous active-high reset (clears all words)
//   wr_en_i    : write strobe
//   wr_idx_i   : word index written
//   wr_data_i  : word written
//   rd_idx_i   : per-port read index, port k at [IDX_W*k +: IDX_W]
//   rd_data_o  : per-port read word, port k at [WORD_W*k +: WORD_W]
module blake2b_msg_bank
    import blake2b_msg_buffer_pkg::*;
#(
    parameter int unsigned BANK_NUM_RD = NUM_RD,
    parameter int unsigned BANK_WORD_W = WORD_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [CNT_W-1:0]                   wr_idx_i,
    input  logic [BANK_WORD_W-1:0]             wr_data_i,
    input  logic [IDX_W*BANK_NUM_RD-1:0]       rd_idx_i,
    output logic [BANK_WORD_W*BANK_NUM_RD-1:0] rd_data_o
);

    logic [BANK_WORD_W-1:0] r_mem [MSG_WORDS];

    // Storage: cleared on reset so no earlier block can leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MSG_WORDS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en_i) begin
            r_mem[wr_idx_i] <= wr_data_i;
        end
    end

    // Zero-latency read ports so the G stage can register its result this cycle.
    for (genvar k = 0; k < int'(BANK_NUM_RD); k++) begin : g_rd
        assign rd_data_o[k*BANK_WORD_W +: BANK_WORD_W] = r_mem[rd_idx_i[k*IDX_W +: IDX_W]];
    end

endmodule

// File: rtl/blake2b_msg_buffer.sv
// Double-buffered BLAKE2b message-block store: one bank fills over a
// valid/ready stream while the other is read by the compression core.
//   clk, rst       : clock, synchronous active-high reset
//   wr_valid_i     : load word valid
//   wr_ready_o     : load word accepted when valid & ready
//   wr_data_i      : message word (first accepted word of a block is m[0])
//   wr_final_i     : sampled with the 16th word; marks the final block
//   blk_valid_o    : active read bank holds a complete block
//   blk_final_o    : final flag of the active read bank
//   blk_release_i  : core done with the active block; frees its bank
//   rd_mindex_i    : per-port message index, port k at [4k+3:4k]
//   rd_m_o         : per-port message word, port k at [64k+63:64k]
module blake2b_msg_buffer
    import blake2b_msg_buffer_pkg::*;
#(
    parameter int unsigned NUM_RD = blake2b_msg_buffer_pkg::NUM_RD,
    parameter int unsigned WORD_W = blake2b_msg_buffer_pkg::WORD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [WORD_W-1:0]          wr_data_i,
    input  logic                       wr_final_i,
    output logic                       blk_valid_o,
    output logic                       blk_final_o,
    input  logic                       blk_release_i,
    input  logic [IDX_W*NUM_RD-1:0]    rd_mindex_i,
    output logic [WORD_W*NUM_RD-1:0]   rd_m_o
);

    logic [1:0]       r_full;
    logic [1:0]       r_final;
    logic             r_wr_bank;
    logic             r_rd_bank;
    msg_cnt_t         r_wcnt;

    logic             w_wr_ready;
    logic             w_blk_valid;
    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic             w_we0;
    logic             w_we1;
    logic [1:0]       w_full_set;
    logic [1:0]       w_full_clr;
    logic [WORD_W*NUM_RD-1:0] w_rd0;
    logic [WORD_W*NUM_RD-1:0] w_rd1;

    // Handshake and status; all forced inactive while reset is asserted.
    assign w_wr_ready  = ~rst & ~r_full[r_wr_bank];
    assign w_blk_valid = ~rst & r_full[r_rd_bank];
    assign wr_ready_o  = w_wr_ready;
    assign blk_valid_o = w_blk_valid;
    assign blk_final_o = w_blk_valid & r_final[r_rd_bank];

    assign w_accept  = wr_valid_i & w_wr_ready;
    assign w_last    = w_accept & is_last_word(r_wcnt);
    assign w_release = blk_release_i & w_blk_valid;
    assign w_we0     = w_accept & ~r_wr_bank;
    assign w_we1     = w_accept & r_wr_bank;

    // A filling bank is never full and a released bank always is, so set
    // and clear can never hit the same bank in one cycle.
    always_comb begin
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        if (w_last) begin
            w_full_set[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_clr[r_rd_bank] = 1'b1;
        end
    end

    // Pointers and per-bank flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_final   <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            if (w_accept) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end
            if (w_last) begin
                r_final[r_wr_bank] <= wr_final_i;
                r_wr_bank          <= ~r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            r_full <= (r_full & ~w_full_clr) | w_full_set;
        end
    end

    blake2b_msg_bank #(
        .BANK_NUM_RD (NUM_RD),
        .BANK_WORD_W (WORD_W)
    ) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_we0),
        .wr_idx_i  (r_wcnt),
        .wr_data_i (wr_data_i),
        .rd_idx_i  (rd_mindex_i),
        .rd_data_o (w_rd0)
    );

    blake2b_msg_bank #(
        .BANK_NUM_RD (NUM_RD),
        .BANK_WORD_W (WORD_W)
    ) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_we1),
        .wr_idx_i  (r_wcnt),
        .wr_data_i (wr_data_i),
        .rd_idx_i  (rd_mindex_i),
        .rd_data_o (w_rd1)
    );

    // Read ports follow the active read bank.
    assign rd_m_o = rst ? '0 : (r_rd_bank ? w_rd1 : w_rd0);

endmodule

// File: tb/tb_blake2b_msg_buffer.sv
module tb_blake2b_msg_buffer;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_valid_i;
    logic           wr_ready_o;
    logic [63:0]    wr_data_i;
    logic           wr_final_i;
    logic           blk_valid_o;
    logic           blk_final_o;
    logic           blk_release_i;
    logic [31:0]    rd_mindex_i;
    logic [511:0]   rd_m_o;

    int n_checks = 0;
    int n_errors = 0;

    blake2b_msg_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_data_i     (wr_data_i),
        .wr_final_i    (wr_final_i),
        .blk_valid_o   (blk_valid_o),
        .blk_final_o   (blk_final_o),
        .blk_release_i (blk_release_i),
        .rd_mindex_i   (rd_mindex_i),
        .rd_m_o        (rd_m_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idx(input int k, input logic [3:0] v);
        rd_mindex_i[4*k +: 4] = v;
    endtask

    function automatic logic [63:0] port(input int k);
        return rd_m_o[64*k +: 64];
    endfunction

    // Stream one 16-word block; optionally release the active bank on word 15.
    task automatic load_block(input logic [63:0] base, input logic fin, input logic rel_last);
        for (int i = 0; i < 16; i++) begin
            int budget = 0;
            wr_valid_i = 1'b1;
            wr_data_i  = base + 64'(i);
            wr_final_i = (i == 15) ? fin : 1'b0;
            blk_release_i = (i == 15) ? rel_last : 1'b0;
            while (!wr_ready_o && budget < 50) begin
                tick();
                budget++;
            end
            chk("ready_wait", 64'(wr_ready_o), 64'd1);
            tick();
        end
        wr_valid_i    = 1'b0;
        wr_final_i    = 1'b0;
        blk_release_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        wr_valid_i    = 1'b1;
        wr_data_i     = 64'hDEAD_BEEF_0000_0001;
        wr_final_i    = 1'b1;
        blk_release_i = 1'b0;
        rd_mindex_i   = 32'h7654_3210;

        // 1. Reset held 3 clocks with valid asserted
        repeat (3) tick();
        chk("rst_ready", 64'(wr_ready_o), 64'd0);
        chk("rst_valid", 64'(blk_valid_o), 64'd0);
        chk("rst_final", 64'(blk_final_o), 64'd0);
        for (int k = 0; k < 8; k++) chk("rst_rdm", port(k), 64'd0);
        rst        = 1'b0;
        wr_valid_i = 1'b0;
        wr_final_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(wr_ready_o), 64'd1);
        chk("post_rst_valid", 64'(blk_valid_o), 64'd0);

        // 2. Single block into bank0
        load_block(64'h1000, 1'b0, 1'b0);
        chk("b1_valid", 64'(blk_valid_o), 64'd1);
        chk("b1_final", 64'(blk_final_o), 64'd0);
        set_idx(3, 4'hA);
        set_idx(0, 4'h0);
        set_idx(7, 4'hF);
        #1;
        chk("b1_p3_mA", port(3), 64'h100A);
        chk("b1_p0_m0", port(0), 64'h1000);
        chk("b1_p7_mF", port(7), 64'h100F);
        chk("b1_ready", 64'(wr_ready_o), 64'd1);

        // 3. Second (final) block into bank1; both full -> backpressure
        load_block(64'h2000, 1'b1, 1'b0);
        chk("bp_ready", 64'(wr_ready_o), 64'd0);
        chk("bp_final", 64'(blk_final_o), 64'd0);
        wr_valid_i = 1'b1;
        wr_data_i  = 64'h3000;
        repeat (3) tick();
        chk("bp_held_ready", 64'(wr_ready_o), 64'd0);
        chk("bp_bank0_m0", port(0), 64'h1000);
        blk_release_i = 1'b1;
        tick();
        blk_release_i = 1'b0;
        chk("rel_valid", 64'(blk_valid_o), 64'd1);
        chk("rel_final", 64'(blk_final_o), 64'd1);
        chk("rel_ready", 64'(wr_ready_o), 64'd1);
        chk("rel_bank1_m0", port(0), 64'h2000);
        chk("rel_bank1_mA", port(3), 64'h200A);

        // 4. Overlap: fill bank0, release bank1 on the 16th word
        load_block(64'h3000, 1'b0, 1'b1);
        chk("ov_valid", 64'(blk_valid_o), 64'd1);
        chk("ov_final", 64'(blk_final_o), 64'd0);
        chk("ov_ready", 64'(wr_ready_o), 64'd1);
        chk("ov_m0", port(0), 64'h3000);
        chk("ov_mF", port(7), 64'h300F);

        // 5. Release bank0, then a spurious release with nothing valid
        blk_release_i = 1'b1;
        tick();
        chk("sp_valid0", 64'(blk_valid_o), 64'd0);
        tick();
        blk_release_i = 1'b0;
        chk("sp_valid1", 64'(blk_valid_o), 64'd0);
        load_block(64'h4000, 1'b1, 1'b0);
        set_idx(1, 4'h5);
        #1;
        chk("sp_valid", 64'(blk_valid_o), 64'd1);
        chk("sp_final", 64'(blk_final_o), 64'd1);
        chk("sp_m5", port(1), 64'h4005);
        chk("sp_m0", port(0), 64'h4000);

        // 6. Reset mid-fill discards everything
        blk_release_i = 1'b1;
        tick();
        blk_release_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 64'h5000 + 64'(i);
            tick();
        end
        wr_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(wr_ready_o), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(blk_valid_o), 64'd0);
        load_block(64'hA0, 1'b0, 1'b0);
        chk("mf_valid", 64'(blk_valid_o), 64'd1);
        for (int half = 0; half < 2; half++) begin
            for (int k = 0; k < 8; k++) set_idx(k, 4'(half*8 + k));
            #1;
            for (int k = 0; k < 8; k++) chk("mf_word", port(k), 64'hA0 + 64'(half*8 + k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
